stepper_ramp: RTL
=================

# stepper_ramp

Acceleration-limited step generator between the control loop and each stepper driver chip. Takes a signed per-wheel target speed, slews the applied speed toward it at a bounded rate, and converts the applied speed into STEP/DIR/EN pulses via a phase accumulator. It also enforces driver timing: enable setup, direction hold, and minimum step width. One instance per wheel.

## Interface
- CLK_HZ, 100_000_000, clock frequency (documentation only)
- ACC_W, 24, phase accumulator width; step rate = |cur_speed| * CLK_HZ / 2^ACC_W
- RAMP_DIV, 100_000, clock cycles per ramp tick (1 kHz)
- ACCEL, 4, max |cur_speed| change per ramp tick
- MAX_SPEED, 511, saturation magnitude for target
- EN_SETUP, 100, cycles from en_n low to first possible step
- STEP_HIGH, 200, step pulse width in cycles (2 µs)
- DIR_HOLD, 20, cycles steps are inhibited after a dir change
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- run_en  in  1  level; 1 = drive motor, 0 = ramp down and disable
- target_speed  in  10  signed target speed; negative = reverse
- step  out  1  driver STEP pulse
- dir  out  1  driver DIR; 1 when cur_speed >= 0, 0 when negative
- en_n  out  1  driver enable, active low
- cur_speed  out  10  signed applied (ramped) speed
- at_target  out  1  high in RUN when cur_speed == saturated target

## Operation
- One clock domain; reset is synchronous and active-low, sampled on the rising edge of clock.
- Reset values: step 0, dir 1, en_n 1, cur_speed 0, at_target 0, state DISABLED, accumulator 0, ramp counter 0, pulse/hold counters 0. Reset asserted mid-operation overrides everything on the next edge.
- Target saturation: tgt = clamp(target_speed, -MAX_SPEED, +MAX_SPEED). -512 maps to -511.
- States:
  - DISABLED: en_n=1, cur_speed=0, no steps. Moves to ENABLING when run_en=1.
  - ENABLING: en_n=0. Counts EN_SETUP cycles, then moves to RUN. If run_en drops, returns to DISABLED.
  - RUN: ramps toward tgt. Moves to STOPPING when run_en=0.
  - STOPPING: ramps toward 0, ignoring target. Returns to RUN if run_en=1. Moves to DISABLED when cur_speed==0 and no step pulse is active.
- Ramp counter counts 0..RAMP_DIV-1 in RUN/STOPPING and is cleared on entering RUN from ENABLING. A tick occurs when the counter reaches RAMP_DIV-1.
- On each tick:
  - if cur<goal: cur += min(ACCEL, goal-cur)
  - if cur>goal: cur -= min(ACCEL, cur-goal)
  - otherwise unchanged
  - cur never overshoots goal.
- Arithmetic is in 11-bit signed to avoid overflow. Result is always within ±MAX_SPEED.
- dir is registered from the sign of the new cur_speed at the tick. cur_speed == 0 gives dir=1. Any dir change loads the hold counter with DIR_HOLD.
- Accumulator (RUN/STOPPING only): acc += |cur_speed| every cycle; a carry out of bit ACC_W-1 requests a step. The accumulator is not cleared on reversal; it is cleared in DISABLED.
- A step request starts a STEP_HIGH-cycle pulse only when no pulse is active and the hold counter is 0. Otherwise the request is dropped (not queued).
- at_target is combinational on registered state: (state==RUN) && cur_speed==tgt.

## Timing
- run_en sampled 1 → en_n low on the next edge.
- The first accumulator add occurs EN_SETUP cycles later, when RUN is entered.
- A step rises on the edge after the carry cycle and stays high exactly STEP_HIGH cycles.
- cur_speed and dir update on the edge following the tick. The dir change and the start of the hold happen on the same edge.
- STOPPING→DISABLED: en_n rises one edge after cur_speed==0 with step low. It never rises while step=1.
- Simultaneous tick and carry: the carry uses the pre-tick cur_speed. A new dir hold suppresses a step request in the same cycle.

## Test plan
Bench parameters: ACC_W=8, RAMP_DIV=10, ACCEL=4, EN_SETUP=5, STEP_HIGH=3, DIR_HOLD=6.
- Reset: hold reset_n=0 with run_en=1 and target 100 → step 0, dir 1, en_n 1, cur_speed 0, at_target 0. Deassert reset → en_n goes low 1 edge later.
- Ramp up: run_en=1, target 20 → en_n low, RUN after 5 cycles. cur_speed is 4, 8, 12, 16, 20 at successive 10-cycle ticks; at_target rises with the 5th value and stays high.
- Step rate: cur_speed held at 16 → one step every 16 cycles, each high exactly 3 cycles, dir=1.
- Reversal: cur 8, target -8 → cur 4, 0, -4, -8 on successive ticks. dir goes to 0 at -4; no step rises within 6 cycles of that edge.
- Saturation: target -512 → cur_speed settles at -511 and never reaches -512. at_target=1 there.
- Shutdown: cur 20, run_en→0 → cur ramps 16, 12, 8, 4, 0, then en_n=1 after the last step pulse ends. Re-assert run_en at cur=8 → back to RUN, en_n stays low throughout.

Source files
------------

// File: rtl/stepper_ramp.sv
// stepper_ramp
// Acceleration-limited STEP/DIR/EN generator for one stepper driver.
// The applied speed slews toward a saturated signed target at ACCEL per ramp
// tick; a phase accumulator turns |cur_speed| into step requests. Driver
// timing (enable setup, direction hold, step width) is enforced here.
//
// Ports
//   clock        in   system clock, all logic on the rising edge
//   reset_n      in   synchronous active-low reset
//   run_en       in   1 = drive motor, 0 = ramp down and disable
//   target_speed in   signed target speed (negative = reverse)
//   step         out  driver STEP pulse, STEP_HIGH cycles wide
//   dir          out  driver DIR, 1 when cur_speed >= 0
//   en_n         out  driver enable, active low
//   cur_speed    out  signed applied (ramped) speed
//   at_target    out  high in RUN when cur_speed equals the saturated target
//
// state      | meaning
// S_DISABLED | driver off, speed and accumulator held at zero
// S_ENABLING | en_n low, waiting EN_SETUP cycles before stepping
// S_RUN      | ramping toward the saturated target, stepping
// S_STOPPING | ramping toward zero; disables once stopped and step is low
module stepper_ramp #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int ACC_W     = 24,
  parameter int RAMP_DIV  = 100_000,
  parameter int ACCEL     = 4,
  parameter int MAX_SPEED = 511,
  parameter int EN_SETUP  = 100,
  parameter int STEP_HIGH = 200,
  parameter int DIR_HOLD  = 20
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              run_en,
  input  logic signed [9:0] target_speed,
  output logic              step,
  output logic              dir,
  output logic              en_n,
  output logic signed [9:0] cur_speed,
  output logic              at_target
);

  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int EW = (EN_SETUP > 1) ? $clog2(EN_SETUP) : 1;
  localparam int PW = (STEP_HIGH > 1) ? $clog2(STEP_HIGH) : 1;
  localparam int HW = (DIR_HOLD > 0) ? $clog2(DIR_HOLD + 1) : 1;
  localparam int SW = ACC_W + 10;

  localparam logic signed [9:0]  MAX_P = 10'(MAX_SPEED);
  localparam logic signed [9:0]  MAX_N = -10'(MAX_SPEED);
  localparam logic signed [10:0] ACC_P = 11'(ACCEL);
  localparam logic signed [10:0] ACC_N = -11'(ACCEL);

  // CLK_HZ only documents the step-rate scaling.
  if (CLK_HZ <= 0) begin : g_clk_hz_invalid
  end

  typedef enum logic [1:0] {S_DISABLED, S_ENABLING, S_RUN, S_STOPPING} state_t;

  state_t                  r_state;
  logic                    r_step;
  logic                    r_dir;
  logic                    r_en_n;
  logic signed [9:0]       r_cur;
  logic [ACC_W-1:0]        r_acc;
  logic [RW-1:0]           r_ramp_cnt;
  logic [EW-1:0]           r_en_cnt;
  logic [PW-1:0]           r_pulse_cnt;
  logic [HW-1:0]           r_hold_cnt;

  logic signed [9:0]       w_tgt;
  logic                    w_active;
  logic                    w_tick;
  logic signed [10:0]      w_goal;
  logic signed [10:0]      w_diff;
  logic signed [10:0]      w_next;
  logic                    w_dir_change;
  logic [9:0]              w_mag;
  logic [SW-1:0]           w_sum;
  logic                    w_carry;
  logic                    w_step_req;

  always_comb begin
    w_tgt = target_speed;
    if (target_speed > MAX_P) w_tgt = MAX_P;
    else if (target_speed < MAX_N) w_tgt = MAX_N;
  end

  assign w_active = (r_state == S_RUN) || (r_state == S_STOPPING);
  assign w_tick   = w_active && (r_ramp_cnt == RW'(RAMP_DIV - 1));
  assign w_goal   = (r_state == S_RUN) ? {w_tgt[9], w_tgt} : 11'sd0;
  assign w_diff   = w_goal - {r_cur[9], r_cur};

  // Step by at most ACCEL, landing exactly on the goal when closer than that.
  always_comb begin
    w_next = w_goal;
    if (w_diff > ACC_P) w_next = {r_cur[9], r_cur} + ACC_P;
    else if (w_diff < ACC_N) w_next = {r_cur[9], r_cur} + ACC_N;
  end

  assign w_dir_change = w_tick && ((~w_next[10]) != r_dir);

  // Carry is any overflow past ACC_W bits; the addend uses the pre-tick speed.
  assign w_mag   = r_cur[9] ? 10'(-r_cur) : 10'(r_cur);
  assign w_sum   = SW'(r_acc) + SW'(w_mag);
  assign w_carry = |w_sum[SW-1:ACC_W];

  // Requests that collide with an active pulse or a direction hold are dropped.
  assign w_step_req = w_active && w_carry && !r_step && (r_hold_cnt == '0) && !w_dir_change;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= S_DISABLED;
      r_step      <= 1'b0;
      r_dir       <= 1'b1;
      r_en_n      <= 1'b1;
      r_cur       <= '0;
      r_acc       <= '0;
      r_ramp_cnt  <= '0;
      r_en_cnt    <= '0;
      r_pulse_cnt <= '0;
      r_hold_cnt  <= '0;
    end else begin
      if (r_step) begin
        if (r_pulse_cnt == '0) r_step <= 1'b0;
        else r_pulse_cnt <= r_pulse_cnt - 1'b1;
      end else if (w_step_req) begin
        r_step      <= 1'b1;
        r_pulse_cnt <= PW'(STEP_HIGH - 1);
      end

      if (w_dir_change) r_hold_cnt <= HW'(DIR_HOLD);
      else if (r_hold_cnt != '0) r_hold_cnt <= r_hold_cnt - 1'b1;

      case (r_state)
        S_DISABLED: begin
          r_cur  <= '0;
          r_acc  <= '0;
          r_en_n <= 1'b1;
          if (run_en) begin
            r_state  <= S_ENABLING;
            r_en_n   <= 1'b0;
            r_en_cnt <= EW'(EN_SETUP - 1);
          end
        end
        S_ENABLING: begin
          if (!run_en) begin
            r_state <= S_DISABLED;
            r_en_n  <= 1'b1;
          end else if (r_en_cnt == '0) begin
            r_state    <= S_RUN;
            r_ramp_cnt <= '0;
          end else begin
            r_en_cnt <= r_en_cnt - 1'b1;
          end
        end
        default: begin
          r_acc <= w_sum[ACC_W-1:0];
          if (w_tick) begin
            r_ramp_cnt <= '0;
            r_cur      <= w_next[9:0];
            r_dir      <= ~w_next[10];
          end else begin
            r_ramp_cnt <= r_ramp_cnt + 1'b1;
          end
          if (r_state == S_RUN) begin
            if (!run_en) r_state <= S_STOPPING;
          end else if (run_en) begin
            r_state <= S_RUN;
          end else if ((r_cur == '0) && !r_step) begin
            r_state <= S_DISABLED;
            r_en_n  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign step      = r_step;
  assign dir       = r_dir;
  assign en_n      = r_en_n;
  assign cur_speed = r_cur;
  assign at_target = (r_state == S_RUN) && (r_cur == w_tgt);

endmodule
